dpram_copy_dma: RTL
===================

// Module: dpram_copy_dma
// PURPOSE
// - Block-copy initiator driving both ports of the 2-block, 1024x16 dual-port RAM: port A reads source, port B writes destination.
// - Moves a contiguous region of up to 1024 words without CPU load/store loops, one word per cycle after a 1-cycle prime.
// - Handles overlapping regions (memmove semantics) and sits beside the CPU, which is granted RAM ports only while busy=0.
// PARAMETERS
// - ADDR_W  10          RAM word-address width
// - DATA_W  16          RAM word width
// - LEN_W   ADDR_W+1    length width; 0..2**ADDR_W inclusive
// PORTS
// - clk          in   1       single clock; all logic posedge
// - rst_n        in   1       reset, asynchronous, active-low
// - start        in   1       1-cycle request; sampled only when busy=0
// - src          in   ADDR_W  first source word address
// - dst          in   ADDR_W  first destination word address
// - len          in   LEN_W   word count
// - busy         out  1       copy in progress; RAM ports owned by this block
// - done         out  1       1-cycle pulse on successful completion (incl. len=0)
// - err          out  1       1-cycle pulse on rejected request
// - mem_en_a     out  1       port A write enable; tied 0 (read-only port)
// - mem_addr_a   out  ADDR_W  port A address
// - mem_rdata_a  in   DATA_W  port A registered read data, valid 1 cycle after address
// - mem_en_b     out  1       port B write enable
// - mem_addr_b   out  ADDR_W  port B address
// - mem_wdata_b  out  DATA_W  port B write data
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; busy, done, err, mem_en_b = 0; mem_addr_a, mem_addr_b, mem_wdata_b = 0.
// - States: IDLE, PRIME, RUN, FINISH, REJECT.
// - IDLE + start: latch src/dst/len; compute in LEN_W+1 bits, no wrap.
//   - src+len > 2**ADDR_W or dst+len > 2**ADDR_W -> REJECT; no RAM write ever issued.
//   - len=0 -> FINISH (done next cycle, no writes).
//   - else -> PRIME; busy=1 from next cycle.
// - Direction: desc=1 iff dst>src and dst<src+len (overlap, dst above); otherwise ascending.
//   - asc: read src,src+1,..; write dst,dst+1,..   desc: read src+len-1 downward; write dst+len-1 downward.
//   - Same-cycle port A read address never equals port B write address in either mode (read leads write by one word).
// - PRIME (1 cycle): mem_addr_a = first read addr; mem_en_b=0.
// - RUN: each cycle mem_en_b=1, mem_addr_b = next dst addr, mem_wdata_b = mem_rdata_a (combinational pass-through),
//   mem_addr_a advances to next source while words remain; exactly len write cycles, then -> FINISH.
// - FINISH: done=1 for one cycle, busy=0 same cycle, -> IDLE. REJECT: err=1 one cycle, busy stays 0, -> IDLE.
// - Latency: start at cycle 0 -> first write cycle 2 -> last write cycle len+1 -> done cycle len+2.
// - start while busy=1, or during FINISH/REJECT: ignored, no queueing.
// - len=1024, src=dst=0: legal, full-memory copy; address counters must not wrap before completion.
// - src==dst: legal; performs len writes of identical data.
// - rst_n low mid-copy: mem_en_b drops immediately (async); partial copy left in RAM; no done/err pulse.
// - mem_en_a held 0 at all times, including reset.
// STRUCTURE
// - Package dma_pkg: state enum (IDLE/PRIME/RUN/FINISH/REJECT), ADDR_W/DATA_W/LEN_W defaults, DEPTH=2**ADDR_W.
// - Sub-module dma_addr_gen: loadable up/down address counter with remaining-word count; instanced twice (src, dst).
// - Top holds FSM, bounds/overlap check, RAM port muxing.
// TESTING
// - Prefill RAM[i]=i; src=0,dst=512,len=4 -> writes at cycles 2..5 to 512..515 = 0..3; done at cycle 6; busy cycles 1..5.
// - Prefill RAM[i]=i; src=10,dst=12,len=5 (overlap) -> descending; RAM[12..16] = 10..14; RAM[10..11] unchanged.
// - src=12,dst=10,len=5 -> ascending; RAM[10..14] = 12..16; no same-cycle A/B address collision (assertion).
// - src=1000,dst=0,len=30 -> err pulse cycle 1, busy never 1, mem_en_b never 1; RAM unchanged.
// - len=0 -> done cycle 1, no writes; len=1024,src=dst=0 -> 1024 writes, done cycle 1026.
// - Second start mid-copy ignored; rst_n low at cycle 3 of len=8 copy -> mem_en_b=0 same cycle, no done.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and default sizes for the dual-port RAM block-copy engine.
package dma_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        FINISH,
        REJECT
    } state_e;

endpackage

// File: rtl/dpram_copy_dma_if.sv
// Request/status and RAM port bundle for the block-copy engine.
// master = the copy engine (drives the RAM ports), slave = CPU/RAM side.
interface dpram_copy_dma_if #(
    parameter int ADDR_W = dma_pkg::ADDR_W,
    parameter int DATA_W = dma_pkg::DATA_W,
    parameter int LEN_W  = ADDR_W + 1
);
    import dma_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_en_a;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [DATA_W-1:0] mem_rdata_a;
    logic              mem_en_b;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [DATA_W-1:0] mem_wdata_b;

    modport master (
        input  start, src, dst, len, mem_rdata_a,
        output busy, done, err, mem_en_a, mem_addr_a, mem_en_b, mem_addr_b, mem_wdata_b
    );

    modport slave (
        output start, src, dst, len, mem_rdata_a,
        input  busy, done, err, mem_en_a, mem_addr_a, mem_en_b, mem_addr_b, mem_wdata_b
    );

endinterface

// File: rtl/dma_addr_gen.sv
// Loadable up/down word-address counter with a remaining-word count.
// The address stops moving on the last word so a full-memory walk never wraps.
module dma_addr_gen #(
    parameter int ADDR_W = dma_pkg::ADDR_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              desc_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LEN_W-1:0]  rem_o
);
    import dma_pkg::*;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              desc_q, desc_d;

    // Next address/count: load picks the first word of the walk, step consumes one word.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        desc_d = desc_q;
        if (load_i) begin
            desc_d = desc_i;
            rem_d  = len_i;
            addr_d = desc_i ? base_i + len_i[ADDR_W-1:0] - ADDR_W'(1) : base_i;
        end else if (step_i && (rem_q != '0)) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q > LEN_W'(1)) begin
                addr_d = desc_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
            desc_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            desc_q <= desc_d;
        end
    end

    assign addr_o = addr_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/dpram_copy_dma.sv
// Block-copy engine: port A reads the source region, port B writes the
// destination one word per cycle after a single prime cycle (memmove-safe).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; CPU owns the RAM ports
// PRIME  | first source address on port A, no write yet
// RUN    | one write per cycle, read stream one word ahead
// FINISH | done pulse, back to IDLE
// REJECT | err pulse for an out-of-range request, back to IDLE
module dpram_copy_dma #(
    parameter int ADDR_W = dma_pkg::ADDR_W,
    parameter int DATA_W = dma_pkg::DATA_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input logic                clk,
    input logic                rst_n,
    dpram_copy_dma_if.master   bus
);
    import dma_pkg::*;

    localparam int EXT_W = LEN_W + 1;
    localparam logic [EXT_W-1:0] DEPTH_X = EXT_W'(2 ** ADDR_W);

    state_e            state_q, state_d;
    logic [EXT_W-1:0]  src_x, dst_x, len_x;
    logic              oob, desc_req, len_zero;
    logic              load, src_step, dst_step;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic [LEN_W-1:0]  src_rem, dst_rem;
    logic              run;
    logic [DATA_W-1:0] wdata;

    // Bounds and overlap are evaluated one bit wider than the length so nothing wraps.
    assign src_x    = EXT_W'(bus.src);
    assign dst_x    = EXT_W'(bus.dst);
    assign len_x    = EXT_W'(bus.len);
    assign oob      = (src_x + len_x > DEPTH_X) || (dst_x + len_x > DEPTH_X);
    assign desc_req = (dst_x > src_x) && (dst_x < src_x + len_x);
    assign len_zero = (bus.len == '0);

    dma_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_src (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .desc_i (desc_req),
        .base_i (bus.src),
        .len_i  (bus.len),
        .step_i (src_step),
        .addr_o (src_addr),
        .rem_o  (src_rem)
    );

    dma_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dst (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .desc_i (desc_req),
        .base_i (bus.dst),
        .len_i  (bus.len),
        .step_i (dst_step),
        .addr_o (dst_addr),
        .rem_o  (dst_rem)
    );

    // Next-state and counter control.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        src_step = 1'b0;
        dst_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (oob) begin
                        state_d = REJECT;
                    end else if (len_zero) begin
                        state_d = FINISH;
                    end else begin
                        load    = 1'b1;
                        state_d = PRIME;
                    end
                end
            end
            PRIME: begin
                src_step = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                src_step = 1'b1;
                dst_step = 1'b1;
                if (dst_rem == LEN_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode straight from state so reset drops the write enable at once.
    // In the final write cycle nothing is left to read, so port A is parked on a
    // word other than the one being written.
    assign run             = (state_q == RUN);
    assign wdata           = run ? bus.mem_rdata_a : '0;
    assign bus.busy        = (state_q == PRIME) || run;
    assign bus.done        = (state_q == FINISH);
    assign bus.err         = (state_q == REJECT);
    assign bus.mem_en_a    = 1'b0;
    assign bus.mem_addr_a  = (run && (src_rem == '0)) ? (dst_addr ^ ADDR_W'(1)) : src_addr;
    assign bus.mem_en_b    = run;
    assign bus.mem_addr_b  = dst_addr;
    assign bus.mem_wdata_b = wdata;

endmodule
